// File: rtl/cpu_io_pkg.sv
// ---------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU I/O interrupt-instruction path:
//   NOP_WORD_DEFAULT  word driven to the processor when no interrupt is queued
//   CH_CTRL/TIMER/VSYNC  conventional channel ids of the on-board sources
//   clog2()           ceiling log2 usable in parameter/localparam expressions
// ---------------------------------------------------------------------------
package cpu_io_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    localparam int CH_CTRL  = 0;
    localparam int CH_TIMER = 1;
    localparam int CH_VSYNC = 2;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/irq_instr_queue_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the channel
// after last_grant and wraps, so the previous winner has lowest priority.
// Ports:
//   req          in   N       request vector
//   last_grant   in   IDX_W   index of the most recent winner
//   grant        out  N       one-hot grant (all zero when no request)
//   grant_idx    out  IDX_W   encoded grant index (0 when no request)
//   grant_valid  out  1       some request was granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import cpu_io_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand_idx;

    // Cyclic search from last_grant+1; the first requester found wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_idx    = '0;
        for (int i = 1; i <= N; i++) begin
            cand_idx = IDX_W'((int'(last_grant) + i) % N);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_instr_queue.sv
// ---------------------------------------------------------------------------
// irq_instr_queue
// Collects interrupt instruction words from NUM_CH sources through a
// round-robin arbiter into a DEPTH-entry FIFO and presents the head word to
// the processor until it is acknowledged.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   src_valid/src_instr     per-channel offer; word i = src_instr[i*DATA_W +: DATA_W]
//   src_ready               one-hot (or zero) accept for this cycle
//   ch_enable               per-channel arbitration mask
//   irq_ack                 processor consumed the head word
//   interrupt_instruction   head word, NOP_WORD while empty
//   irq_pending             FIFO non-empty
//   irq_channel             source channel of the head word (0 while empty)
//   fifo_count              occupancy 0..DEPTH
//   accept_count            saturating count of accepted words
// ---------------------------------------------------------------------------
module irq_instr_queue
    import cpu_io_pkg::*;
#(
    parameter int                 NUM_CH   = 4,
    parameter int                 DEPTH    = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             src_valid,
    input  logic [NUM_CH*DATA_W-1:0]      src_instr,
    output logic [NUM_CH-1:0]             src_ready,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic                          irq_ack,
    output logic [DATA_W-1:0]             interrupt_instruction,
    output logic                          irq_pending,
    output logic [clog2(NUM_CH)-1:0]      irq_channel,
    output logic [clog2(DEPTH):0]         fifo_count,
    output logic [15:0]                   accept_count
);

    localparam int CH_W  = clog2(NUM_CH);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_word_q [DEPTH];
    logic [CH_W-1:0]   mem_ch_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [15:0]       accept_count_q, accept_count_d;

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] grant_s;
    logic [CH_W-1:0]   grant_idx_s;
    logic              grant_valid_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] push_word_s;

    assign req_s   = src_valid & ch_enable;
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req         (req_s),
        .last_grant  (last_grant_q),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Full is the registered flag, so a same-cycle pop never frees a slot
    // for a push; ready is also independent of irq_ack.
    assign src_ready   = grant_s & {NUM_CH{~full_s}};
    assign push_s      = grant_valid_s & ~full_s;
    assign pop_s       = irq_ack & ~empty_s;
    assign push_word_s = src_instr[grant_idx_s*DATA_W +: DATA_W];

    // Next-state for pointers, occupancy, arbitration history and statistics.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        last_grant_d   = last_grant_q;
        accept_count_d = accept_count_q;
        if (push_s) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            last_grant_d = grant_idx_s;
            if (accept_count_q == 16'hFFFF) begin
                accept_count_d = accept_count_q;
            end else begin
                accept_count_d = accept_count_q + 16'd1;
            end
        end else begin
            accept_count_d = accept_count_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the queue and makes channel 0
    // the first winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_grant_q   <= CH_W'(NUM_CH - 1);
            accept_count_q <= 16'd0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_grant_q   <= last_grant_d;
            accept_count_q <= accept_count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_word_q[wr_ptr_q] <= push_word_s;
            mem_ch_q[wr_ptr_q]   <= grant_idx_s;
        end
    end

    assign interrupt_instruction = empty_s ? NOP_WORD : mem_word_q[rd_ptr_q];
    assign irq_channel           = empty_s ? {CH_W{1'b0}} : mem_ch_q[rd_ptr_q];
    assign irq_pending           = ~empty_s;
    assign fifo_count            = count_q;
    assign accept_count          = accept_count_q;

endmodule

// File: tb/tb_irq_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_irq_instr_queue
// Drives directed scenarios followed by random traffic. A queue-based model
// predicts per-cycle state and the order of words handed to the processor;
// a separate monitor compares DUT outputs against those predictions.
// ---------------------------------------------------------------------------
module tb_irq_instr_queue;

    localparam int          NUM_CH = 4;
    localparam int          DEPTH  = 8;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   src_valid;
    logic [127:0] src_instr;
    logic [3:0]   src_ready;
    logic [3:0]   ch_enable;
    logic         irq_ack;
    logic [31:0]  interrupt_instruction;
    logic         irq_pending;
    logic [1:0]   irq_channel;
    logic [3:0]   fifo_count;
    logic [15:0]  accept_count;

    always #5 clock = ~clock;

    irq_instr_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .src_valid             (src_valid),
        .src_instr             (src_instr),
        .src_ready             (src_ready),
        .ch_enable             (ch_enable),
        .irq_ack               (irq_ack),
        .interrupt_instruction (interrupt_instruction),
        .irq_pending           (irq_pending),
        .irq_channel           (irq_channel),
        .fifo_count            (fifo_count),
        .accept_count          (accept_count)
    );

    typedef struct {
        int          ch;
        logic [31:0] word;
    } item_t;

    typedef struct {
        bit          chk;
        logic [3:0]  ready;
        int          count;
        int          acc;
        logic [31:0] head;
        int          head_ch;
    } cyc_t;

    item_t mq[$];      // model FIFO contents
    item_t sb_q[$];    // words expected at the processor, in order
    cyc_t  cyc_q[$];   // per-cycle expectations
    int    m_last  = NUM_CH - 1;
    int    m_acc   = 0;
    bit    started = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_instr(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // One clock cycle of stimulus plus the model's view of what that cycle does.
    task automatic drive_cycle(input logic [3:0] v, input logic [127:0] instr,
                               input logic [3:0] en, input bit ack, input bit rst);
        cyc_t  c;
        item_t it;
        int    g;
        int    cnd;
        bit    full;
        @(posedge clock);
        #2;
        src_valid = v;
        src_instr = instr;
        ch_enable = en;
        irq_ack   = rst ? 1'b0 : ack;
        reset     = rst;

        full = (mq.size() == DEPTH);
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            cnd = (m_last + k) % NUM_CH;
            if (g < 0 && v[cnd] && en[cnd]) g = cnd;
        end

        c.chk     = started;
        c.ready   = (g >= 0 && !full) ? (4'b0001 << g) : 4'b0000;
        c.count   = mq.size();
        c.acc     = m_acc;
        c.head    = (mq.size() > 0) ? mq[0].word : NOP;
        c.head_ch = (mq.size() > 0) ? mq[0].ch : 0;
        cyc_q.push_back(c);
        started = 1'b1;

        if (rst) begin
            mq.delete();
            sb_q.delete();
            m_last = NUM_CH - 1;
            m_acc  = 0;
        end else begin
            if (irq_ack && mq.size() > 0) begin
                it = mq.pop_front();
            end
            if (g >= 0 && !full) begin
                it.ch   = g;
                it.word = instr[g*32 +: 32];
                mq.push_back(it);
                sb_q.push_back(it);
                m_last = g;
                if (m_acc < 65535) m_acc++;
            end
        end
    endtask

    // Monitor: compare per-cycle state and every consumed word.
    always @(negedge clock) begin
        cyc_t  c;
        item_t it;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            if (c.chk) begin
                check("src_ready",    {28'd0, src_ready},    {28'd0, c.ready});
                check("fifo_count",   {28'd0, fifo_count},   32'(c.count));
                check("accept_count", {16'd0, accept_count}, 32'(c.acc));
                check("irq_pending",  {31'd0, irq_pending},  (c.count > 0) ? 32'd1 : 32'd0);
                check("head_word",    interrupt_instruction, c.head);
                check("head_channel", {30'd0, irq_channel},  32'(c.head_ch));
            end
            if (irq_ack === 1'b1 && irq_pending === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    check("pop_word",    interrupt_instruction, it.word);
                    check("pop_channel", {30'd0, irq_channel},  32'(it.ch));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        src_valid = 4'b0000;
        src_instr = 128'd0;
        ch_enable = 4'b1111;
        irq_ack   = 1'b0;

        repeat (2) drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b0, 1'b1);

        // 1: single word from channel 1, then acknowledge it
        drive_cycle(4'b0010, mk_instr(32'd0, 32'hDEAD_0001, 32'd0, 32'd0), 4'b1111, 1'b0, 1'b0);
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b0, 1'b0);
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b0, 1'b0);

        // 2: all channels continuously valid, fill to full and stay refused
        for (int i = 0; i < 12; i++) begin
            drive_cycle(4'b1111, mk_instr(32'hA000_0000 + i*16, 32'hA000_0001 + i*16,
                                          32'hA000_0002 + i*16, 32'hA000_0003 + i*16),
                        4'b1111, 1'b0, 1'b0);
        end

        // 3: full with ack and ch0 valid: no push this cycle, push next cycle
        drive_cycle(4'b0001, mk_instr(32'hB000_0000, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b1, 1'b0);
        drive_cycle(4'b0001, mk_instr(32'hB000_0001, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);

        // 4: channel 2 masked
        for (int i = 0; i < 6; i++) begin
            drive_cycle(4'b1111, mk_instr(32'hC000_0000 + i*16, 32'hC000_0001 + i*16,
                                          32'hC000_0002 + i*16, 32'hC000_0003 + i*16),
                        4'b1011, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);

        // 5: three pushes, reset mid-operation, then channel 0 wins first
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b1111, mk_instr(32'hD000_0000 + i, 32'hD100_0000 + i,
                                          32'hD200_0000 + i, 32'hD300_0000 + i),
                        4'b1111, 1'b0, 1'b0);
        end
        drive_cycle(4'b0001, mk_instr(32'hD0FF_0000, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b0, 1'b1);
        drive_cycle(4'b1111, mk_instr(32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003),
                    4'b1111, 1'b0, 1'b0);
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);

        // 6: ack while empty, then push/pop pairs across pointer wrap
        for (int i = 0; i < 3; i++) drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);
        drive_cycle(4'b0001, mk_instr(32'hF000_0000, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(4'b0001, mk_instr(32'hF000_0000 + i, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b1, 1'b0);
        end
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b1, 1'b0);
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b0, 1'b0);

        // Random traffic with occasional masks and resets
        for (int i = 0; i < 800; i++) begin
            drive_cycle(4'($urandom),
                        {$urandom, $urandom, $urandom, $urandom},
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
                        ($urandom_range(0, 99) < 45),
                        ($urandom_range(0, 199) == 0));
        end
        drive_cycle(4'b0000, 128'd0, 4'b1111, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
